mdu_sequencer: RTL and testbench

- Multi-cycle controller for the RV32M multiply/divide operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Replaces the single-cycle combinational mul/div paths in the EX stage with an iterative shift-add / restoring-divide engine.
- Raises BUSY so the hazard unit stalls IF/ID/EX until the result is ready.
- Handles all RISC-V divide-by-zero and overflow corner cases in hardware.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_iter_datapath.sv | 45 ++++
 rtl/mdu_sequencer.sv | 148 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package mdu_pkg;
  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN_DEF-1:0] INT_MIN  = {1'b1, {(XLEN_DEF-1){1'b0}}};
  localparam logic [XLEN_DEF-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
endpackage

// File: rtl/mdu_iter_datapath.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes.
// {hi,lo} holds the product, or remainder (hi) and quotient (lo).
module mdu_iter_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  logic [XLEN-1:0] m;
  logic [XLEN:0]   sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, m};
  end

  // m is the multiplicand or divisor; lo starts as multiplier or dividend
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      m  <= '0;
    end else if (load) begin
      hi <= '0;
      m  <= div ? b : a;
      lo <= div ? a : b;
    end else if (step) begin
      if (div) begin
        hi <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        lo <= {lo[XLEN-2:0], ~diff[XLEN]};
      end else begin
        hi <= sum[XLEN:1];
        lo <= {sum[0], lo[XLEN-1:1]};
      end
    end
  end
endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle sequencer: FSM, fast paths, sign fix and stall handshake.
// Optional MDU_ZERO_BYPASS_EN: multiplies with a zero operand complete in one cycle.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [2:0]      OPCODE,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [2:0]      op;
  logic            s1, s2;
  logic [CW-1:0]   cnt;

  logic            sgn1, sgn2, fast, zero_mul, accept, dp_div, neg;
  logic [XLEN-1:0] mag1, mag2, fast_res, fix_res, hi, lo, quo_f, rem_f;
  logic [2*XLEN-1:0] prod_f;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (OPCODE)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sgn1 = DATA1[XLEN-1];
        sgn2 = DATA2[XLEN-1];
      end
      OP_MULHSU: sgn1 = DATA1[XLEN-1];
      default: ;
    endcase
    mag1 = sgn1 ? -DATA1 : DATA1;
    mag2 = sgn2 ? -DATA2 : DATA2;
  end

`ifdef MDU_ZERO_BYPASS_EN
  assign zero_mul = ~OPCODE[2] & ((DATA1 == '0) | (DATA2 == '0));
`else
  assign zero_mul = 1'b0;
`endif

  // Results that need no iteration: divide by zero, signed overflow, zero bypass
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (OPCODE[2] && DATA2 == '0) begin
      fast     = 1'b1;
      fast_res = OPCODE[1] ? DATA1 : '1;
    end else if ((OPCODE == OP_DIV || OPCODE == OP_REM) && DATA1 == MIN_NEG && DATA2 == '1) begin
      fast     = 1'b1;
      fast_res = OPCODE[1] ? '0 : MIN_NEG;
    end else if (zero_mul) begin
      fast = 1'b1;
    end
  end

  assign accept = (state == S_IDLE) && START && !FLUSH;
  assign dp_div = (state == S_IDLE) ? OPCODE[2] : op[2];

  mdu_iter_datapath #(.XLEN(XLEN)) u_dp (
    .clk  (CLK),
    .rst  (RESET),
    .load (accept && !fast),
    .step (state == S_CALC),
    .div  (dp_div),
    .a    (mag1),
    .b    (mag2),
    .hi   (hi),
    .lo   (lo)
  );

  always_comb begin
    case (op)
      OP_MUL, OP_MULH, OP_DIV: neg = s1 ^ s2;
      OP_MULHSU, OP_REM:       neg = s1;
      default:                 neg = 1'b0;
    endcase
    prod_f = neg ? -{hi, lo} : {hi, lo};
    quo_f  = neg ? -lo : lo;
    rem_f  = neg ? -hi : hi;
    case (op)
      OP_MUL:                       fix_res = prod_f[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_f[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_f;
      default:                      fix_res = rem_f;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
      cnt    <= '0;
      op     <= '0;
      s1     <= 1'b0;
      s2     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          op <= OPCODE;
          s1 <= sgn1;
          s2 <= sgn2;
          if (fast) begin
            RESULT <= fast_res;
            DONE   <= 1'b1;
          end else begin
            state <= S_CALC;
            BUSY  <= 1'b1;
            cnt   <= CW'(XLEN-1);
          end
        end
        S_CALC: if (FLUSH) begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end else if (cnt == '0) begin
          state <= S_FIX;
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          if (!FLUSH) begin
            RESULT <= fix_res;
            DONE   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random ops vs a 64-bit model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        FLUSH = 1'b0;
  logic [2:0]  OPCODE = 3'b000;
  logic [31:0] DATA1 = '0, DATA2 = '0;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_exp = '0;
  bit done_seen = 1'b0;

  mdu_sequencer #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH), .OPCODE(OPCODE),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    r  = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; r = p[31:0];  end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
      OP_DIV:    r = (b == 0) ? ALL_ONES : (a == INT_MIN && b == ALL_ONES) ? INT_MIN
                   : 32'($signed(a) / $signed(b));
      OP_REM:    r = (b == 0) ? a : (a == INT_MIN && b == ALL_ONES) ? 32'h0
                   : 32'($signed(a) % $signed(b));
      OP_DIVU:   r = (b == 0) ? ALL_ONES : a / b;
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == INT_MIN && b == ALL_ONES) return 1;
`ifdef MDU_ZERO_BYPASS_EN
    if (!op[2] && (a == 0 || b == 0)) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return ALL_ONES;
      2:       return INT_MIN;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (DONE) done_seen = 1'b1;
  endtask

  // Leaves the bench at #1 after the accepting edge (cycle 1)
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    START = 1'b1; OPCODE = op; DATA1 = a; DATA2 = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit poke);
    int cyc, lat, busy_bad;
    lat = exp_lat(op, a, b);
    busy_bad = 0;
    start_op(op, a, b);
    cyc = 1;
    while (!DONE && cyc < 100) begin
      if (BUSY !== (lat > 1)) busy_bad++;
      if (poke && cyc == 5) begin
        START = 1'b1; OPCODE = ~op; DATA1 = $urandom; DATA2 = $urandom;
      end
      if (poke && cyc == 8) START = 1'b0;
      @(posedge CLK);
      #1;
      cyc++;
    end
    START = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " result"}, RESULT, exp);
    chk({tag, " busy"}, 32'(busy_bad), 32'd0);
    chk({tag, " busy_in_done"}, {31'b0, BUSY}, 32'd0);
    last_exp = exp;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset busy", {31'b0, BUSY}, 32'd0);
    chk("reset done", {31'b0, DONE}, 32'd0);
    chk("reset result", RESULT, 32'h0);
    RESET = 1'b0;

    run_op("mul_7_neg3", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_op("mulhu_ones", OP_MULHU, ALL_ONES, ALL_ONES, 32'hFFFFFFFE, 1'b0);
    run_op("mulh_ones", OP_MULH, ALL_ONES, ALL_ONES, 32'h00000000, 1'b0);
    run_op("mulhsu_ones", OP_MULHSU, ALL_ONES, ALL_ONES, 32'hFFFFFFFF, 1'b0);
    run_op("mul_ones", OP_MUL, ALL_ONES, ALL_ONES, 32'h00000001, 1'b0);
    run_op("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
    run_op("rem_neg7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
    run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd3, 1'b0);
    run_op("remu_7_2", OP_REMU, 32'd7, 32'd2, 32'd1, 1'b0);
    run_op("div_by0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op("div_ovf", OP_DIV, INT_MIN, ALL_ONES, INT_MIN, 1'b0);
    run_op("rem_ovf", OP_REM, INT_MIN, ALL_ONES, 32'h0, 1'b0);
    run_op("divu_start_ignored", OP_DIVU, 32'd1000, 32'd7, 32'd142, 1'b1);

    // Flush mid-CALC drops the operation
    start_op(OP_DIVU, 32'd100, 32'd7);
    done_seen = 1'b0;
    repeat (9) tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush_calc busy", {31'b0, BUSY}, 32'd0);
    chk("flush_calc result", RESULT, last_exp);
    repeat (40) tick();
    chk("flush_calc no_done", {31'b0, done_seen}, 32'd0);

    // FLUSH beats START in IDLE
    @(negedge CLK);
    START = 1'b1; FLUSH = 1'b1; OPCODE = OP_MUL; DATA1 = 32'd3; DATA2 = 32'd3;
    done_seen = 1'b0;
    tick();
    START = 1'b0; FLUSH = 1'b0;
    chk("flush_idle busy", {31'b0, BUSY}, 32'd0);
    repeat (3) tick();
    chk("flush_idle no_done", {31'b0, done_seen}, 32'd0);

    // Flush in the FIX cycle suppresses the write
    start_op(OP_MUL, 32'd9, 32'd9);
    done_seen = 1'b0;
    repeat (32) tick();
    chk("fix busy", {31'b0, BUSY}, 32'd1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush_fix busy", {31'b0, BUSY}, 32'd0);
    chk("flush_fix no_done", {31'b0, done_seen}, 32'd0);
    chk("flush_fix result", RESULT, last_exp);

    // Reset during CALC clears everything
    run_op("mul_3_5", OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);
    start_op(OP_MUL, 32'd6, 32'd7);
    repeat (4) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_calc busy", {31'b0, BUSY}, 32'd0);
    chk("rst_calc done", {31'b0, DONE}, 32'd0);
    chk("rst_calc result", RESULT, 32'h0);
    done_seen = 1'b0;
    repeat (40) tick();
    chk("rst_calc no_done", {31'b0, done_seen}, 32'd0);

    run_op("mul_zero", OP_MUL, 32'd0, 32'd5, 32'd0, 1'b0);
    run_op("mulhu_zero", OP_MULHU, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = rnd_val();
      b  = rnd_val();
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_model(op, a, b), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
